// File: rtl/iir_sub_inverse.sv
// Inverse of the first-order subtract filter y[n] = x[n] - y[n-1]: x[n] = y[n] + y[n-1].
// The carry-save input is resolved, reconstructed against the stored history and queued in a 2-deep output FIFO.
module iir_sub_inverse #(
   parameter int width_p       = 16,
   parameter int count_width_p = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [width_p-1:0]       in_sum,
   input  logic [width_p-1:0]       in_carry,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [width_p-1:0]       out_sample,
   output logic [count_width_p-1:0] sample_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready depends only on registered state, never on out_ready. clear suppresses both transfers.
   logic                     r_run;
   logic [1:0]               r_occ;
   logic                     r_rd_ptr;
   logic                     r_wr_ptr;
   logic [width_p-1:0]       r_mem [2];
   logic [width_p-1:0]       r_y_prev;
   logic [count_width_p-1:0] r_count;

   logic [width_p-1:0]       w_y;
   logic [width_p-1:0]       w_x;
   logic                     w_push;
   logic                     w_pop;

   // The carry word has weight 2; its MSB falls off the top.
   assign w_y = in_sum + {in_carry[width_p-2:0], 1'b0};
   assign w_x = w_y + r_y_prev;

   // r_run holds in_ready low until the first edge after reset is released.
   assign in_ready     = r_run && (r_occ != 2'd2);
   assign out_valid    = (r_occ != 2'd0);
   assign out_sample   = out_valid ? r_mem[r_rd_ptr] : '0;
   assign sample_count = r_count;

   assign w_push = in_valid && in_ready && !clear;
   assign w_pop  = out_valid && out_ready && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run    <= 1'b0;
         r_occ    <= 2'd0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_y_prev <= '0;
         r_count  <= '0;
      end else begin
         r_run <= 1'b1;
         if (clear) begin
            r_occ    <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_y_prev <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= ~r_wr_ptr;
               r_y_prev <= w_y;
               r_count  <= r_count + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
               2'b10:   r_occ <= r_occ + 2'd1;
               2'b01:   r_occ <= r_occ - 2'd1;
               default: r_occ <= r_occ;
            endcase
         end
      end
   end

   // Storage needs no reset: out_sample is gated to 0 whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_x;
      end
   end

endmodule

// File: tb/tb_iir_sub_inverse.sv
// Self-checking bench for iir_sub_inverse: directed vector table, hand-written corner sequences,
// and a randomized round trip through a forward subtract filter model.
module tb_iir_sub_inverse;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_sum;
   logic [W-1:0]  in_carry;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sample;
   logic [CW-1:0] sample_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];

   iir_sub_inverse #(.width_p(W), .count_width_p(CW)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_carry(in_carry),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sample(out_sample), .sample_count(sample_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      in_valid = 1'b0;
      step();
      clear    = 1'b0;
   endtask

   task automatic offer(input logic [W-1:0] s, input logic [W-1:0] c);
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
   endtask

   typedef struct {
      logic          clr_first;
      logic [W-1:0]  sum;
      logic [W-1:0]  carry;
      logic [W-1:0]  exp_out;
      logic [CW-1:0] exp_cnt;
   } vec_t;

   vec_t vecs[4];

   logic [W-1:0] x_cur, y_cur, y_prev_m, c_rnd;
   logic         acc, pop;
   int           cnt;

   initial begin
      vecs[0] = '{1'b0, 16'h0001, 16'h0002, 16'h0005, 4'd1};
      vecs[1] = '{1'b0, 16'hFFFE, 16'h0000, 16'h0003, 4'd2};
      vecs[2] = '{1'b0, 16'h000C, 16'h0000, 16'h000A, 4'd3};
      vecs[3] = '{1'b1, 16'hFFFF, 16'h8001, 16'h0001, 4'd1};

      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_sum = '0; in_carry = '0;
      #12;
      check("rst_in_ready",  32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(sample_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors, out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].clr_first) begin
            do_clear();
            check($sformatf("vec%0d_clr_out_valid", i), 32'(out_valid), 32'd0);
         end
         offer(vecs[i].sum, vecs[i].carry);
         step();
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("vec%0d_out_sample", i), 32'(out_sample), 32'(vecs[i].exp_out));
         check($sformatf("vec%0d_count", i), 32'(sample_count), 32'(vecs[i].exp_cnt));
      end
      in_valid = 1'b0;
      step();
      check("vec_drain_out_valid", 32'(out_valid), 32'd0);

      // Backpressure: 3 offers with the output stalled
      do_clear();
      out_ready = 1'b0;
      offer(16'd3, 16'd0); step();
      offer(16'd5, 16'd0); step();
      check("bp_in_ready_full", 32'(in_ready), 32'd0);
      offer(16'd9, 16'd0); step();
      check("bp_stalled_head", 32'(out_sample), 32'd3);
      check("bp_stalled_count", 32'(sample_count), 32'd2);
      out_ready = 1'b1;
      step();
      check("bp_second_out", 32'(out_sample), 32'd8);
      check("bp_in_ready_again", 32'(in_ready), 32'd1);
      step();
      check("bp_third_out", 32'(out_sample), 32'd14);
      check("bp_count", 32'(sample_count), 32'd3);
      in_valid = 1'b0;
      step();
      check("bp_empty", 32'(out_valid), 32'd0);

      // Clear has priority over a same-cycle input
      offer(16'd7, 16'd0); step();
      clear = 1'b1;
      offer(16'd4, 16'd0); step();
      clear = 1'b0;
      check("clr_out_valid", 32'(out_valid), 32'd0);
      check("clr_count", 32'(sample_count), 32'd0);
      step();
      check("clr_next_out", 32'(out_sample), 32'd4);
      check("clr_next_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      step();

      // Random round trip through a forward subtract filter
      do_clear();
      exp_q.delete();
      cnt = 0;
      y_prev_m = '0;
      x_cur = 16'($urandom);
      y_cur = x_cur - y_prev_m;
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         c_rnd     = 16'($urandom);
         in_carry  = c_rnd;
         in_sum    = y_cur - (c_rnd << 1);
         out_ready = ($urandom_range(0, 3) != 0);
         check("rt_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
         check("rt_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         if (pop && exp_q.size() > 0) check("rt_out_sample", 32'(out_sample), 32'(exp_q[0]));
         step();
         if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(x_cur);
            y_prev_m = y_cur;
            cnt++;
            x_cur = 16'($urandom);
            y_cur = x_cur - y_prev_m;
         end
         check("rt_count", 32'(sample_count), 32'(cnt % 16));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
         check("drain_out_sample", 32'(out_sample), 32'(exp_q[0]));
         step();
         void'(exp_q.pop_front());
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset with two buffered entries
      do_clear();
      out_ready = 1'b0;
      offer(16'd3, 16'd0); step();
      offer(16'd5, 16'd0); step();
      in_valid = 1'b0;
      check("ar_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", 32'(out_valid), 32'd0);
      check("ar_count", 32'(sample_count), 32'd0);
      check("ar_out_sample", 32'(out_sample), 32'd0);
      check("ar_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("ar_after_in_ready", 32'(in_ready), 32'd1);
      check("ar_after_out_valid", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
